// File: rtl/peripheral_pkg.sv
// Shared types for the peripheral register block arbiter: FSM states, port indices, window base.
// Pure declarations; no timing or flow-control behaviour of its own.
package peripheral_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Base of the peripheral window as seen by the memory decoder upstream.
  localparam logic [31:0] PERIPH_BASE = 32'h0000_1000;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick2
  import peripheral_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |valid;
    if (&valid) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = valid[PORT_DBG] ? PORT_DBG : PORT_CPU;
    end
  end

endmodule

// File: rtl/peripheral_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between the CPU and debug ports.
// Ack ACCESS_CYCLES+1 cycles after capture; requesters hold valid until ack, one access in flight.
module peripheral_arbiter
  import peripheral_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_address,
  input  logic [31:0] req0_data,
  output logic        req0_ack,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_address,
  input  logic [31:0] req1_data,
  output logic        req1_ack,
  output logic [31:0] req1_rdata,
  output logic [31:0] address,
  output logic [31:0] input_data,
  output logic        should_write,
  input  logic [31:0] output_data
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_done;
  logic          last_grant_q;
  logic          win_q;
  req_t          req_q;
  logic [31:0]   rdata_q;
  logic          grant_valid;
  logic          grant_idx;

  rr_pick2 u_pick (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  if (cnt_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture and read-data registers; last_grant resets to DBG so CPU wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      last_grant_q <= PORT_DBG;
      win_q        <= PORT_CPU;
      req_q        <= '0;
      rdata_q      <= '0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        win_q        <= grant_idx;
        last_grant_q <= grant_idx;
        cnt_q        <= '0;
        if (grant_idx == PORT_DBG) begin
          req_q <= '{write: req1_write, address: req1_address, data: req1_data};
        end else begin
          req_q <= '{write: req0_write, address: req0_address, data: req0_data};
        end
      end
      if (state_q == ACCESS) begin
        if (cnt_done) begin
          rdata_q <= output_data;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    address      = '0;
    input_data   = '0;
    should_write = 1'b0;
    req0_ack     = 1'b0;
    req1_ack     = 1'b0;
    req0_rdata   = '0;
    req1_rdata   = '0;
    case (state_q)
      ACCESS: begin
        address      = req_q.address;
        input_data   = req_q.data;
        // Strobe only in the first access cycle so a write lands exactly once.
        should_write = req_q.write && (cnt_q == '0);
      end
      RESP: begin
        if (win_q == PORT_DBG) begin
          req1_ack   = 1'b1;
          req1_rdata = rdata_q;
        end else begin
          req0_ack   = 1'b1;
          req0_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_peripheral_arbiter.sv
// Scoreboard bench for peripheral_arbiter: ACCESS_CYCLES=1 instance plus an ACCESS_CYCLES=3 instance.
module tb_peripheral_arbiter;

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b1, req0_write = 1'b0;
  logic [31:0] req0_address = '0, req0_data = '0;
  logic        req1_valid = 1'b1, req1_write = 1'b0;
  logic [31:0] req1_address = '0, req1_data = '0;
  logic [31:0] output_data = '0;
  logic        req0_ack, req1_ack, should_write;
  logic [31:0] req0_rdata, req1_rdata, address, input_data;

  logic        v3 = 1'b0;
  logic [31:0] a3 = '0, od3 = '0;
  logic        ack3_0, ack3_1, sw3;
  logic [31:0] rd3_0, rd3_1, addr3, idat3;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, ack_cnt = 0, sw_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  peripheral_arbiter #(.ACCESS_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
    .req0_data(req0_data), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
    .req1_data(req1_data), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .address(address), .input_data(input_data), .should_write(should_write),
    .output_data(output_data)
  );

  peripheral_arbiter #(.ACCESS_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset),
    .req0_valid(v3), .req0_write(1'b0), .req0_address(a3),
    .req0_data(32'h0), .req0_ack(ack3_0), .req0_rdata(rd3_0),
    .req1_valid(1'b0), .req1_write(1'b0), .req1_address(32'h0),
    .req1_data(32'h0), .req1_ack(ack3_1), .req1_rdata(rd3_1),
    .address(addr3), .input_data(idat3), .should_write(sw3),
    .output_data(od3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: bus strobes and acks are matched against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (should_write) begin
        sw_cnt++;
        if (exp_q.size() == 0) begin
          chk("sw_unexpected", 32'd1, 32'd0);
        end else begin
          chk("sw_is_write", 32'(exp_q[0].wr), 32'd1);
          chk("sw_addr", address, exp_q[0].addr);
          chk("sw_data", input_data, exp_q[0].data);
        end
      end
      if (req0_ack || req1_ack) begin
        chk("ack_exclusive", 32'(req0_ack & req1_ack), 32'd0);
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_port", 32'(req1_ack), 32'(mon_e.port));
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          if (!mon_e.wr) chk("rdata", mon_e.port ? req1_rdata : req0_rdata, mon_e.rdata);
          chk("loser_rdata", mon_e.port ? req0_rdata : req1_rdata, 32'd0);
          ack_cnt++;
        end
      end
    end
  end

  task automatic push(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input int ack_c);
    exp_t e;
    e.port = p; e.wr = w; e.addr = a; e.data = d; e.rdata = rd; e.ack_cyc = ack_c;
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input int target);
    for (int i = 0; i < 40 && ack_cnt < target; i++) begin
      @(negedge clock); #1;
    end
    if (ack_cnt < target) chk("ack_timeout", ack_cnt, target);
  endtask

  task automatic do_req(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd);
    int target;
    @(negedge clock); #1;
    push(p, w, a, d, rd, cyc + 2);
    target = ack_cnt + 1;
    if (p) begin
      req1_valid = 1'b1; req1_write = w; req1_address = a; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_write = w; req0_address = a; req0_data = d;
    end
    wait_acks(target);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int s0, c0, target;
    bit got;

    // Reset held with both requesters asserting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("rst_acks", 32'({req0_ack, req1_ack}), 32'd0);
      chk("rst_rdata", req0_rdata | req1_rdata, 32'd0);
      chk("rst_addr", address, 32'd0);
      chk("rst_wdata", input_data, 32'd0);
      chk("rst_sw", 32'(should_write), 32'd0);
    end

    // Release with both held: strict alternation starting at port 0, 3-cycle spacing.
    output_data  = 32'h0000_00A5;
    req0_address = 32'h10;
    req1_address = 32'h14;
    reset        = 1'b0;
    push(1'b0, 1'b0, 32'h10, 32'h0, 32'hA5, cyc + 2);
    push(1'b1, 1'b0, 32'h14, 32'h0, 32'hA5, cyc + 5);
    push(1'b0, 1'b0, 32'h10, 32'h0, 32'hA5, cyc + 8);
    push(1'b1, 1'b0, 32'h14, 32'h0, 32'hA5, cyc + 11);
    wait_acks(ack_cnt + 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single write from port 0: one strobe only.
    s0 = sw_cnt;
    do_req(1'b0, 1'b1, 32'h6, 32'h8000_0000, 32'h0);
    chk("wr_strobe_count", sw_cnt - s0, 32'd1);

    // Single read from port 1: no strobe, read data returned.
    output_data = 32'h1;
    s0 = sw_cnt;
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 32'h1);
    chk("rd_strobe_count", sw_cnt - s0, 32'd0);

    // Reset during a port 1 write access.
    @(negedge clock); #1;
    s0 = sw_cnt;
    push(1'b1, 1'b1, 32'h8, 32'h55, 32'h0, cyc + 2);
    req1_valid = 1'b1; req1_write = 1'b1; req1_address = 32'h8; req1_data = 32'h55;
    @(negedge clock); #1;
    chk("mid_sw_before", 32'(should_write), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("mid_sw_after", 32'(should_write), 32'd0);
      chk("mid_no_ack", 32'({req0_ack, req1_ack}), 32'd0);
    end
    chk("mid_strobe_count", sw_cnt - s0, 32'd1);
    exp_q.delete();
    reset = 1'b0;
    req1_write = 1'b0;
    req0_write = 1'b0;
    req0_address = 32'h20;
    req1_address = 32'h24;
    output_data = 32'h0000_3C3C;
    push(1'b0, 1'b0, 32'h20, 32'h0, 32'h3C3C, cyc + 2);
    push(1'b1, 1'b0, 32'h24, 32'h0, 32'h3C3C, cyc + 5);
    target = ack_cnt + 2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_acks(target);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("sb_drained", exp_q.size(), 32'd0);

    // ACCESS_CYCLES=3: read data must be sampled in the last access cycle.
    @(negedge clock); #1;
    c0 = cyc; od3 = 32'h0; a3 = 32'hC; v3 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (cyc == c0 + 3) od3 = 32'h1;
      if (ack3_0) begin
        got = 1'b1;
        break;
      end
    end
    v3 = 1'b0;
    chk("ac3_ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("ac3_ack_cycle", cyc, c0 + 4);
      chk("ac3_rdata", rd3_0, 32'h1);
      chk("ac3_other_ack", 32'(ack3_1), 32'd0);
      chk("ac3_sw", 32'(sw3), 32'd0);
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
